mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the instruction-fetch side (pc -> imem) and the

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and unified-memory port shared by the core and mem_port_arbiter.
// Slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req_in;
  logic [ADDR_W-1:0]     i_addr_in;
  logic                  i_gnt_out;
  logic                  i_rvalid_out;
  logic [DATA_W-1:0]     i_rdata_out;

  logic                  d_req_in;
  logic                  d_we_in;
  logic [ADDR_W-1:0]     d_addr_in;
  logic [DATA_W-1:0]     d_wdata_in;
  logic [DATA_W/8-1:0]   d_wstrb_in;
  logic                  d_gnt_out;
  logic                  d_rvalid_out;
  logic [DATA_W-1:0]     d_rdata_out;

  logic                  mem_en_out;
  logic                  mem_we_out;
  logic [ADDR_W-1:0]     mem_addr_out;
  logic [DATA_W-1:0]     mem_wdata_out;
  logic [DATA_W/8-1:0]   mem_wstrb_out;
  logic [DATA_W-1:0]     mem_rdata_in;

  modport slave (
    input  i_req_in, i_addr_in,
    input  d_req_in, d_we_in, d_addr_in, d_wdata_in, d_wstrb_in,
    input  mem_rdata_in,
    output i_gnt_out, i_rvalid_out, i_rdata_out,
    output d_gnt_out, d_rvalid_out, d_rdata_out,
    output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out
  );

  modport master (
    output i_req_in, i_addr_in,
    output d_req_in, d_we_in, d_addr_in, d_wdata_in, d_wstrb_in,
    output mem_rdata_in,
    input  i_gnt_out, i_rvalid_out, i_rdata_out,
    input  d_gnt_out, d_rvalid_out, d_rdata_out,
    input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter for one single-port memory; grant is same-cycle, rvalid MEM_LAT cycles later.
// Requesters stall by holding req until gnt; one transaction outstanding, new grant allowed in the response cycle.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic              clkin,
  input logic              nrst_in,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);
  localparam logic       OWN_I    = 1'b0;
  localparam logic       OWN_D    = 1'b1;

  state_t       state_q;
  logic [3:0]   lat_cnt_q;
  logic         owner_q;
  logic         last_owner_q;
  logic         store_q;

  logic         accept;
  logic         resp;
  logic         grant;
  logic         win_d;
  logic         store_d;

  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   wdata_mux;
  logic [DATA_W/8-1:0] wstrb_mux;
  logic                we_mux;
  logic [DATA_W-1:0]   i_rdata_mux;
  logic [DATA_W-1:0]   d_rdata_mux;

  // Gating with nrst_in keeps every output at 0 while reset is held, even with requests pending.
  assign resp    = nrst_in && (state_q == BUSY) && (lat_cnt_q == 4'd1);
  assign accept  = nrst_in && ((state_q == IDLE) || resp);
  assign grant   = accept && (bus.i_req_in || bus.d_req_in);
  assign win_d   = (bus.i_req_in && bus.d_req_in) ? ~last_owner_q : bus.d_req_in;
  assign store_d = (win_d == OWN_D) && bus.d_we_in;

  always_comb begin
    addr_mux    = '0;
    wdata_mux   = '0;
    wstrb_mux   = '0;
    we_mux      = 1'b0;
    i_rdata_mux = '0;
    d_rdata_mux = '0;
    if (grant) begin
      if (win_d == OWN_D) begin
        addr_mux  = bus.d_addr_in;
        wdata_mux = bus.d_wdata_in;
        wstrb_mux = bus.d_wstrb_in;
        we_mux    = bus.d_we_in;
      end else begin
        addr_mux  = bus.i_addr_in;
      end
    end
    if (resp && (owner_q == OWN_I)) begin
      i_rdata_mux = bus.mem_rdata_in;
    end
    if (resp && (owner_q == OWN_D) && !store_q) begin
      d_rdata_mux = bus.mem_rdata_in;
    end
  end

  assign bus.i_gnt_out     = grant && (win_d == OWN_I);
  assign bus.d_gnt_out     = grant && (win_d == OWN_D);
  assign bus.i_rvalid_out  = resp && (owner_q == OWN_I);
  assign bus.d_rvalid_out  = resp && (owner_q == OWN_D);
  assign bus.i_rdata_out   = i_rdata_mux;
  assign bus.d_rdata_out   = d_rdata_mux;
  assign bus.mem_en_out    = grant;
  assign bus.mem_we_out    = we_mux;
  assign bus.mem_addr_out  = addr_mux;
  assign bus.mem_wdata_out = wdata_mux;
  assign bus.mem_wstrb_out = wstrb_mux;

  // A grant in the response cycle overrides the return to IDLE, giving back-to-back issue.
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      store_q      <= 1'b0;
    end else if (grant) begin
      state_q      <= BUSY;
      lat_cnt_q    <= LAT_INIT;
      owner_q      <= win_d;
      last_owner_q <= win_d;
      store_q      <= store_d;
    end else if (state_q == BUSY) begin
      if (lat_cnt_q == 4'd1) begin
        state_q   <= IDLE;
        lat_cnt_q <= 4'd0;
      end else begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT 1, 2, 3 and 15 sharing one clock and reset.
module tb_mem_port_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b15 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1))  u1  (.clkin(clk), .nrst_in(nrst), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2))  u2  (.clkin(clk), .nrst_in(nrst), .bus(b2));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3))  u3  (.clkin(clk), .nrst_in(nrst), .bus(b3));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) u15 (.clkin(clk), .nrst_in(nrst), .bus(b15));

  // {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we}
  wire [5:0] f1  = {b1.i_gnt_out, b1.i_rvalid_out, b1.d_gnt_out, b1.d_rvalid_out, b1.mem_en_out, b1.mem_we_out};
  wire [5:0] f2  = {b2.i_gnt_out, b2.i_rvalid_out, b2.d_gnt_out, b2.d_rvalid_out, b2.mem_en_out, b2.mem_we_out};
  wire [5:0] f3  = {b3.i_gnt_out, b3.i_rvalid_out, b3.d_gnt_out, b3.d_rvalid_out, b3.mem_en_out, b3.mem_we_out};
  wire [5:0] f15 = {b15.i_gnt_out, b15.i_rvalid_out, b15.d_gnt_out, b15.d_rvalid_out, b15.mem_en_out, b15.mem_we_out};

  logic [5:0]  t2 [9] = '{6'b001010, 6'b000000, 6'b100110, 6'b000000, 6'b011010,
                          6'b000000, 6'b100110, 6'b000000, 6'b010000};
  logic [5:0]  ef;
  logic [31:0] ed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    b1.i_req_in = 0;  b1.i_addr_in = 0;  b1.d_req_in = 0;  b1.d_we_in = 0;
    b1.d_addr_in = 0; b1.d_wdata_in = 0; b1.d_wstrb_in = 0; b1.mem_rdata_in = 0;
    b2.i_req_in = 0;  b2.i_addr_in = 0;  b2.d_req_in = 0;  b2.d_we_in = 0;
    b2.d_addr_in = 0; b2.d_wdata_in = 0; b2.d_wstrb_in = 0; b2.mem_rdata_in = 0;
    b3.i_req_in = 0;  b3.i_addr_in = 0;  b3.d_req_in = 0;  b3.d_we_in = 0;
    b3.d_addr_in = 0; b3.d_wdata_in = 0; b3.d_wstrb_in = 0; b3.mem_rdata_in = 0;
    b15.i_req_in = 0;  b15.i_addr_in = 0;  b15.d_req_in = 0;  b15.d_we_in = 0;
    b15.d_addr_in = 0; b15.d_wdata_in = 0; b15.d_wstrb_in = 0; b15.mem_rdata_in = 0;

    // Reset: outputs held at 0 even with a request present
    b2.i_req_in = 1; b2.i_addr_in = 32'h100;
    mid();
    chk("rst_flags", 32'(f2), 32'h0);
    chk("rst_addr", b2.mem_addr_out, 32'h0);
    nxt();
    b2.i_req_in = 0; nrst = 1;
    mid();
    chk("idle_flags", 32'(f2), 32'h0);

    // Test 1: single fetch, MEM_LAT=2
    nxt();
    b2.i_req_in = 1; b2.i_addr_in = 32'h100;
    mid();
    chk("t1_gnt_flags", 32'(f2), 32'b100010);
    chk("t1_mem_addr", b2.mem_addr_out, 32'h100);
    nxt();
    b2.i_req_in = 0;
    mid();
    chk("t1_c1_flags", 32'(f2), 32'h0);
    nxt();
    b2.mem_rdata_in = 32'h0050_0093;
    mid();
    chk("t1_rv_flags", 32'(f2), 32'b010000);
    chk("t1_i_rdata", b2.i_rdata_out, 32'h0050_0093);
    chk("t1_d_rdata", b2.d_rdata_out, 32'h0);
    nxt();
    mid();
    chk("t1_c3_flags", 32'(f2), 32'h0);
    chk("t1_c3_rdata", b2.i_rdata_out, 32'h0);

    // Test 2: contention, data wins first then alternates
    nxt();
    b2.i_req_in = 1; b2.i_addr_in = 32'h200;
    b2.d_req_in = 1; b2.d_addr_in = 32'h300; b2.d_we_in = 0;
    for (int k = 0; k < 9; k++) begin
      b2.mem_rdata_in = 32'hCAFE_0000 + 32'(k);
      mid();
      ef = t2[k];
      chk($sformatf("t2_flags_c%0d", k), 32'(f2), 32'(ef));
      ed = ef[4] ? 32'hCAFE_0000 + 32'(k) : 32'h0;
      chk($sformatf("t2_i_rdata_c%0d", k), b2.i_rdata_out, ed);
      ed = ef[2] ? 32'hCAFE_0000 + 32'(k) : 32'h0;
      chk($sformatf("t2_d_rdata_c%0d", k), b2.d_rdata_out, ed);
      if (k == 0) chk("t2_first_addr", b2.mem_addr_out, 32'h300);
      if (k == 2) chk("t2_second_addr", b2.mem_addr_out, 32'h200);
      nxt();
      if (k == 6) begin
        b2.i_req_in = 0; b2.d_req_in = 0;
      end
    end

    // Test 3: store, MEM_LAT=2
    b2.d_req_in = 1; b2.d_we_in = 1; b2.d_addr_in = 32'h2000;
    b2.d_wdata_in = 32'hDEAD_BEEF; b2.d_wstrb_in = 4'hF;
    mid();
    chk("t3_gnt_flags", 32'(f2), 32'b001011);
    chk("t3_addr", b2.mem_addr_out, 32'h2000);
    chk("t3_wdata", b2.mem_wdata_out, 32'hDEAD_BEEF);
    chk("t3_wstrb", 32'(b2.mem_wstrb_out), 32'hF);
    nxt();
    b2.d_req_in = 0;
    mid();
    chk("t3_c1_flags", 32'(f2), 32'h0);
    chk("t3_c1_wdata", b2.mem_wdata_out, 32'h0);
    nxt();
    b2.mem_rdata_in = 32'h1234_5678;
    mid();
    chk("t3_ack_flags", 32'(f2), 32'b000100);
    chk("t3_d_rdata", b2.d_rdata_out, 32'h0);
    nxt();

    // Test 4: back-to-back fetches, MEM_LAT=1
    for (int k = 0; k < 5; k++) begin
      b1.i_req_in = (k < 3);
      b1.i_addr_in = 32'(4 * k);
      b1.mem_rdata_in = 32'h1000 + 32'(4 * (k - 1));
      mid();
      ef = {(k < 3), (k >= 1 && k <= 3), 2'b00, (k < 3), 1'b0};
      chk($sformatf("t4_flags_c%0d", k), 32'(f1), 32'(ef));
      ed = (k >= 1 && k <= 3) ? 32'h1000 + 32'(4 * (k - 1)) : 32'h0;
      chk($sformatf("t4_i_rdata_c%0d", k), b1.i_rdata_out, ed);
      ed = (k < 3) ? 32'(4 * k) : 32'h0;
      chk($sformatf("t4_addr_c%0d", k), b1.mem_addr_out, ed);
      nxt();
    end

    // Test 5: reset while BUSY, MEM_LAT=3
    b3.d_req_in = 1; b3.d_addr_in = 32'h40;
    mid();
    chk("t5_gnt_flags", 32'(f3), 32'b001010);
    nxt();
    b3.d_req_in = 0;
    mid();
    chk("t5_c1_flags", 32'(f3), 32'h0);
    nxt();
    b3.mem_rdata_in = 32'h77; b3.i_req_in = 1; b3.i_addr_in = 32'h500;
    nrst = 0;
    #1;
    chk("t5_rst_flags", 32'(f3), 32'h0);
    chk("t5_rst_rdata", b3.d_rdata_out, 32'h0);
    chk("t5_rst_addr", b3.mem_addr_out, 32'h0);
    mid();
    chk("t5_rst_mid_flags", 32'(f3), 32'h0);
    nxt();
    nrst = 1; b3.i_req_in = 0;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk($sformatf("t5_post_flags_c%0d", k), 32'(f3), 32'h0);
      nxt();
    end

    // Test 6: single load, MEM_LAT=15
    b15.d_req_in = 1; b15.d_we_in = 0; b15.d_addr_in = 32'h80;
    mid();
    chk("t6_gnt_flags", 32'(f15), 32'b001010);
    nxt();
    b15.d_req_in = 0;
    for (int k = 1; k <= 16; k++) begin
      b15.mem_rdata_in = 32'hF00D_0000 + 32'(k);
      mid();
      ef = (k == 15) ? 6'b000100 : 6'b000000;
      chk($sformatf("t6_flags_c%0d", k), 32'(f15), 32'(ef));
      ed = (k == 15) ? 32'hF00D_000F : 32'h0;
      chk($sformatf("t6_d_rdata_c%0d", k), b15.d_rdata_out, ed);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
